// File: rtl/writeback_arbiter.sv
// Round-robin arbiter that shares two registered writeback/wakeup ports between
// NUM_REQ result requesters and drains requesters younger than a redirect flush.
module writeback_arbiter #(
  parameter int NUM_REQ      = 3,
  parameter int PREG_WIDTH   = 6,
  parameter int DATA_WIDTH   = 64,
  parameter int ROB_SIZE_LOG = 6
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic [NUM_REQ-1:0]               req_valid,
  output logic [NUM_REQ-1:0]               req_ready,
  input  logic [NUM_REQ-1:0]               req_need_to_wb,
  input  logic [NUM_REQ*PREG_WIDTH-1:0]    req_prd,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_data,
  input  logic [NUM_REQ-1:0]               req_robidx_flag,
  input  logic [NUM_REQ*ROB_SIZE_LOG-1:0]  req_robidx,
  output logic                             writeback0_valid,
  output logic                             writeback0_need_to_wb,
  output logic [PREG_WIDTH-1:0]            writeback0_prd,
  output logic [DATA_WIDTH-1:0]            writeback0_data,
  output logic                             writeback0_robidx_flag,
  output logic [ROB_SIZE_LOG-1:0]          writeback0_robidx,
  output logic                             writeback1_valid,
  output logic                             writeback1_need_to_wb,
  output logic [PREG_WIDTH-1:0]            writeback1_prd,
  output logic [DATA_WIDTH-1:0]            writeback1_data,
  output logic                             writeback1_robidx_flag,
  output logic [ROB_SIZE_LOG-1:0]          writeback1_robidx,
  input  logic                             flush_valid,
  input  logic                             flush_robidx_flag,
  input  logic [ROB_SIZE_LOG-1:0]          flush_robidx
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [PREG_WIDTH-1:0]   prd_arr    [NUM_REQ];
  logic [DATA_WIDTH-1:0]   data_arr   [NUM_REQ];
  logic [ROB_SIZE_LOG-1:0] robidx_arr [NUM_REQ];

  logic [NUM_REQ-1:0] squash, eligible, grant_mask;
  logic               g0_vld, g1_vld;
  logic [PTR_W-1:0]   g0_idx, g1_idx, last_idx, scan_idx;
  logic [PTR_W:0]     scan_sum;
  logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;

  logic                    wb0_valid_q, wb0_ntw_q, wb0_flag_q;
  logic [PREG_WIDTH-1:0]   wb0_prd_q;
  logic [DATA_WIDTH-1:0]   wb0_data_q;
  logic [ROB_SIZE_LOG-1:0] wb0_robidx_q;
  logic                    wb1_valid_q, wb1_ntw_q, wb1_flag_q;
  logic [PREG_WIDTH-1:0]   wb1_prd_q;
  logic [DATA_WIDTH-1:0]   wb1_data_q;
  logic [ROB_SIZE_LOG-1:0] wb1_robidx_q;

  always_comb begin
    squash = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      prd_arr[i]    = req_prd[i*PREG_WIDTH +: PREG_WIDTH];
      data_arr[i]   = req_data[i*DATA_WIDTH +: DATA_WIDTH];
      robidx_arr[i] = req_robidx[i*ROB_SIZE_LOG +: ROB_SIZE_LOG];
      // Flag mismatch means the ROB wrapped between the two, inverting the index order.
      squash[i] = flush_valid &
                  ((flush_robidx_flag ^ req_robidx_flag[i]) ^ (flush_robidx < robidx_arr[i]));
    end
    eligible = req_valid & ~squash & {NUM_REQ{~reset}};

    g0_vld   = 1'b0;
    g1_vld   = 1'b0;
    g0_idx   = '0;
    g1_idx   = '0;
    scan_sum = '0;
    scan_idx = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      scan_sum = {1'b0, rr_ptr_q} + (PTR_W+1)'(k);
      if (scan_sum >= (PTR_W+1)'(NUM_REQ)) scan_sum = scan_sum - (PTR_W+1)'(NUM_REQ);
      scan_idx = scan_sum[PTR_W-1:0];
      if (eligible[scan_idx]) begin
        if (!g0_vld) begin
          g0_vld = 1'b1;
          g0_idx = scan_idx;
        end else if (!g1_vld) begin
          g1_vld = 1'b1;
          g1_idx = scan_idx;
        end
      end
    end

    grant_mask = '0;
    if (g0_vld) grant_mask[g0_idx] = 1'b1;
    if (g1_vld) grant_mask[g1_idx] = 1'b1;
    req_ready = (req_valid & squash & {NUM_REQ{~reset}}) | grant_mask;

    last_idx = g1_vld ? g1_idx : g0_idx;
    rr_ptr_d = rr_ptr_q;
    if (g0_vld) rr_ptr_d = (last_idx == PTR_W'(NUM_REQ-1)) ? '0 : last_idx + 1'b1;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rr_ptr_q     <= '0;
      wb0_valid_q  <= 1'b0;
      wb0_ntw_q    <= 1'b0;
      wb0_prd_q    <= '0;
      wb0_data_q   <= '0;
      wb0_flag_q   <= 1'b0;
      wb0_robidx_q <= '0;
      wb1_valid_q  <= 1'b0;
      wb1_ntw_q    <= 1'b0;
      wb1_prd_q    <= '0;
      wb1_data_q   <= '0;
      wb1_flag_q   <= 1'b0;
      wb1_robidx_q <= '0;
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      wb0_valid_q <= g0_vld;
      wb1_valid_q <= g1_vld;
      // Idle ports keep their payload; only valid drops.
      if (g0_vld) begin
        wb0_ntw_q    <= req_need_to_wb[g0_idx];
        wb0_prd_q    <= prd_arr[g0_idx];
        wb0_data_q   <= data_arr[g0_idx];
        wb0_flag_q   <= req_robidx_flag[g0_idx];
        wb0_robidx_q <= robidx_arr[g0_idx];
      end
      if (g1_vld) begin
        wb1_ntw_q    <= req_need_to_wb[g1_idx];
        wb1_prd_q    <= prd_arr[g1_idx];
        wb1_data_q   <= data_arr[g1_idx];
        wb1_flag_q   <= req_robidx_flag[g1_idx];
        wb1_robidx_q <= robidx_arr[g1_idx];
      end
    end
  end

  assign writeback0_valid       = wb0_valid_q;
  assign writeback0_need_to_wb  = wb0_ntw_q;
  assign writeback0_prd         = wb0_prd_q;
  assign writeback0_data        = wb0_data_q;
  assign writeback0_robidx_flag = wb0_flag_q;
  assign writeback0_robidx      = wb0_robidx_q;
  assign writeback1_valid       = wb1_valid_q;
  assign writeback1_need_to_wb  = wb1_ntw_q;
  assign writeback1_prd         = wb1_prd_q;
  assign writeback1_data        = wb1_data_q;
  assign writeback1_robidx_flag = wb1_flag_q;
  assign writeback1_robidx      = wb1_robidx_q;

endmodule

// File: tb/tb_writeback_arbiter.sv
// Directed bench for writeback_arbiter: grant order, squash, pointer and reset behaviour.
module tb_writeback_arbiter;

  localparam int NR = 3;
  localparam int PW = 6;
  localparam int DW = 64;
  localparam int RW = 6;

  logic             clock = 1'b0;
  logic             reset;
  logic [NR-1:0]    req_valid, req_ready, req_need_to_wb, req_robidx_flag;
  logic [NR*PW-1:0] req_prd;
  logic [NR*DW-1:0] req_data;
  logic [NR*RW-1:0] req_robidx;
  logic             wb0_valid, wb0_ntw, wb0_flag, wb1_valid, wb1_ntw, wb1_flag;
  logic [PW-1:0]    wb0_prd, wb1_prd;
  logic [DW-1:0]    wb0_data, wb1_data;
  logic [RW-1:0]    wb0_robidx, wb1_robidx;
  logic             flush_valid, flush_robidx_flag;
  logic [RW-1:0]    flush_robidx;

  int checks = 0;
  int failures = 0;

  always #5 clock = ~clock;

  writeback_arbiter #(.NUM_REQ(NR), .PREG_WIDTH(PW), .DATA_WIDTH(DW), .ROB_SIZE_LOG(RW)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_need_to_wb(req_need_to_wb),
    .req_prd(req_prd), .req_data(req_data),
    .req_robidx_flag(req_robidx_flag), .req_robidx(req_robidx),
    .writeback0_valid(wb0_valid), .writeback0_need_to_wb(wb0_ntw), .writeback0_prd(wb0_prd),
    .writeback0_data(wb0_data), .writeback0_robidx_flag(wb0_flag), .writeback0_robidx(wb0_robidx),
    .writeback1_valid(wb1_valid), .writeback1_need_to_wb(wb1_ntw), .writeback1_prd(wb1_prd),
    .writeback1_data(wb1_data), .writeback1_robidx_flag(wb1_flag), .writeback1_robidx(wb1_robidx),
    .flush_valid(flush_valid), .flush_robidx_flag(flush_robidx_flag), .flush_robidx(flush_robidx)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int i, input logic ntw, input logic [PW-1:0] prd,
                         input logic [DW-1:0] data, input logic flag, input logic [RW-1:0] idx);
    req_need_to_wb[i]       = ntw;
    req_prd[i*PW +: PW]     = prd;
    req_data[i*DW +: DW]    = data;
    req_robidx_flag[i]      = flag;
    req_robidx[i*RW +: RW]  = idx;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    req_valid = '1;
    req_need_to_wb = '0; req_prd = '0; req_data = '0; req_robidx_flag = '0; req_robidx = '0;
    flush_valid = 1'b0; flush_robidx_flag = 1'b0; flush_robidx = '0;
    set_req(0, 1'b1, 6'd10, 64'h100, 1'b0, 6'd1);
    set_req(1, 1'b1, 6'd11, 64'h101, 1'b1, 6'd2);
    set_req(2, 1'b0, 6'd12, 64'h102, 1'b0, 6'd3);

    // Reset held two cycles with every requester valid
    tick();
    #1 chk("rst_ready", 64'(req_ready), 64'b000);
    chk("rst_wb0_valid", 64'(wb0_valid), 64'd0);
    chk("rst_wb1_valid", 64'(wb1_valid), 64'd0);
    tick();
    chk("rst_wb0_prd", 64'(wb0_prd), 64'd0);
    reset = 1'b0;
    #1 chk("grant_01_ready", 64'(req_ready), 64'b011);

    tick();
    chk("c1_wb0_valid", 64'(wb0_valid), 64'd1);
    chk("c1_wb0_prd", 64'(wb0_prd), 64'd10);
    chk("c1_wb0_data", wb0_data, 64'h100);
    chk("c1_wb1_valid", 64'(wb1_valid), 64'd1);
    chk("c1_wb1_prd", 64'(wb1_prd), 64'd11);
    chk("c1_wb1_data", wb1_data, 64'h101);
    chk("c1_wb1_flag", 64'(wb1_flag), 64'd1);
    chk("c1_wb1_robidx", 64'(wb1_robidx), 64'd2);
    #1 chk("grant_20_ready", 64'(req_ready), 64'b101);

    tick();
    chk("c2_wb0_prd", 64'(wb0_prd), 64'd12);
    chk("c2_wb0_ntw", 64'(wb0_ntw), 64'd0);
    chk("c2_wb0_valid", 64'(wb0_valid), 64'd1);
    chk("c2_wb1_prd", 64'(wb1_prd), 64'd10);
    #1 chk("grant_12_ready", 64'(req_ready), 64'b110);

    tick();
    chk("c3_wb0_prd", 64'(wb0_prd), 64'd11);
    chk("c3_wb1_prd", 64'(wb1_prd), 64'd12);
    // Only req1 valid from here; pointer is back at 0
    req_valid = 3'b010;
    set_req(1, 1'b1, 6'd7, 64'hDEAD, 1'b0, 6'd20);
    #1 chk("solo_ready_a", 64'(req_ready), 64'b010);

    tick();
    chk("solo_wb0_valid", 64'(wb0_valid), 64'd1);
    chk("solo_wb0_prd", 64'(wb0_prd), 64'd7);
    chk("solo_wb0_data", wb0_data, 64'hDEAD);
    chk("solo_wb1_valid", 64'(wb1_valid), 64'd0);
    chk("solo_wb1_hold", 64'(wb1_prd), 64'd12);
    #1 chk("solo_ready_b", 64'(req_ready), 64'b010);

    tick();
    chk("solo2_wb0_valid", 64'(wb0_valid), 64'd1);
    chk("solo2_wb1_valid", 64'(wb1_valid), 64'd0);
    // Flush (0,10): req0 (0,12) and req2 (1,3) younger, req1 (0,5) older
    req_valid = 3'b111;
    set_req(0, 1'b1, 6'd30, 64'hA0, 1'b0, 6'd12);
    set_req(1, 1'b1, 6'd31, 64'hA1, 1'b0, 6'd5);
    set_req(2, 1'b1, 6'd32, 64'hA2, 1'b1, 6'd3);
    flush_valid = 1'b1; flush_robidx_flag = 1'b0; flush_robidx = 6'd10;
    #1 chk("flush_ready", 64'(req_ready), 64'b111);

    tick();
    chk("flush_wb0_valid", 64'(wb0_valid), 64'd1);
    chk("flush_wb0_prd", 64'(wb0_prd), 64'd31);
    chk("flush_wb1_valid", 64'(wb1_valid), 64'd0);
    // Wrap: flush (1,2) vs req0 (0,60) -> older
    req_valid = 3'b001;
    set_req(0, 1'b1, 6'd40, 64'hB0, 1'b0, 6'd60);
    flush_robidx_flag = 1'b1; flush_robidx = 6'd2;
    #1 chk("wrap_ready", 64'(req_ready), 64'b001);

    tick();
    chk("wrap_wb0_valid", 64'(wb0_valid), 64'd1);
    chk("wrap_wb0_prd", 64'(wb0_prd), 64'd40);
    chk("wrap_wb0_robidx", 64'(wb0_robidx), 64'd60);
    set_req(0, 1'b1, 6'd41, 64'hB1, 1'b1, 6'd2);
    #1 chk("equal_ready", 64'(req_ready), 64'b001);

    tick();
    chk("equal_wb0_valid", 64'(wb0_valid), 64'd1);
    chk("equal_wb0_prd", 64'(wb0_prd), 64'd41);
    chk("equal_wb0_flag", 64'(wb0_flag), 64'd1);
    // Pointer is now 1; grant req1 alone so the pointer moves to 2
    flush_valid = 1'b0;
    req_valid = 3'b010;
    #1 chk("pre_rst_ready", 64'(req_ready), 64'b010);

    tick();
    chk("pre_rst_wb0_valid", 64'(wb0_valid), 64'd1);
    chk("pre_rst_wb0_prd", 64'(wb0_prd), 64'd31);
    reset = 1'b1;
    req_valid = 3'b111;
    #1 chk("midrst_ready", 64'(req_ready), 64'b000);

    tick();
    chk("midrst_wb0_valid", 64'(wb0_valid), 64'd0);
    chk("midrst_wb1_valid", 64'(wb1_valid), 64'd0);
    chk("midrst_wb0_prd", 64'(wb0_prd), 64'd0);
    reset = 1'b0;
    #1 chk("post_rst_ptr0_ready", 64'(req_ready), 64'b011);

    tick();
    chk("post_rst_wb0_prd", 64'(wb0_prd), 64'd41);
    chk("post_rst_wb1_prd", 64'(wb1_prd), 64'd31);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/writeback_arbiter.md
Name: writeback_arbiter

Overview:
- Shares the two writeback/wakeup ports (writeback0_*, writeback1_*) between NUM_REQ execution-unit result requesters: ALU, MUL/DIV, LSU by default.
- Feeds the issue queues' wakeup inputs and the register file write ports.
- Round-robin grant, at most two winners per cycle, registered outputs.
- Squashes results younger than a redirect flush.

Parameters:
NUM_REQ, 3, number of result requesters (2..8)
PREG_WIDTH, 6, physical register index width
DATA_WIDTH, 64, result data width
ROB_SIZE_LOG, 6, ROB index width (flag bit is separate)

Ports:
clock  in  1  single clock, rising edge
reset  in  1  synchronous, active-high reset
req_valid  in  NUM_REQ  requester i holds a result
req_ready  out  NUM_REQ  requester i result consumed (granted or squashed) this cycle
req_need_to_wb  in  NUM_REQ  result writes a preg
req_prd  in  NUM_REQ*PREG_WIDTH  destination preg, slice i
req_data  in  NUM_REQ*DATA_WIDTH  result data, slice i
req_robidx_flag  in  NUM_REQ  ROB wrap flag
req_robidx  in  NUM_REQ*ROB_SIZE_LOG  ROB index
writeback0_valid / writeback1_valid  out  1  port carries a result
writeback0_need_to_wb / writeback1_need_to_wb  out  1  forwarded need_to_wb
writeback0_prd / writeback1_prd  out  PREG_WIDTH  forwarded prd
writeback0_data / writeback1_data  out  DATA_WIDTH  forwarded data
writeback0_robidx_flag / writeback1_robidx_flag  out  1  forwarded flag
writeback0_robidx / writeback1_robidx  out  ROB_SIZE_LOG  forwarded robidx
flush_valid  in  1  redirect flush
flush_robidx_flag  in  1  flush ROB flag
flush_robidx  in  ROB_SIZE_LOG  flush ROB index

Behaviour:
- Reset (sync, active-high): writeback*_valid=0; all other writeback* outputs=0; rr_ptr=0. req_ready is combinational, so it is 0 during reset.
- Squash test: requester i is younger iff flush_valid & ((flush_robidx_flag ^ req_robidx_flag[i]) ^ (flush_robidx < req_robidx[i])). Equal flag and idx is not younger.
- Eligible[i] = req_valid[i] & ~squash[i].
- Squashed valid requester: req_ready[i]=1 the same cycle (drained); nothing is forwarded.
- Grant:
  - Scan eligible requesters in order rr_ptr, rr_ptr+1, ... mod NUM_REQ.
  - First hit goes to port0, second hit to port1.
  - req_ready[i]=1 for the granted requesters; ungranted eligible requesters see req_ready=0.
  - Requesters must hold req_* stable until req_ready.
- Latency: grant in cycle N -> writebackX_* valid with that requester's fields in cycle N+1, for exactly one cycle. No combinational path from req_* to writeback*.
- Port0 always carries the first winner. writeback1_valid=1 implies writeback0_valid=1 in the same cycle.
- Pointer:
  - If any grant: rr_ptr <= (index of last winner + 1) mod NUM_REQ.
  - No grant: hold.
  - Squash-only drains do not move rr_ptr.
- Idle port: valid=0; other fields hold their previous values.
- The outputs are already registered when flush_valid arrives. Those results are not recalled; the issue queue and ROB tolerate them.
- reset asserted mid-operation: next cycle outputs are invalid and rr_ptr=0. In-flight grants are lost; requesters are also reset.
- Only one eligible requester: it gets port0 every cycle it is valid (back-to-back allowed).
- Starvation bound: any eligible requester is granted within ceil(NUM_REQ/2) cycles.
- need_to_wb=0 results still occupy a port; the ROB needs completion.

Test Plan:
- Reset held 2 cycles with all req_valid=1 -> req_ready=0, writeback*_valid=0. First cycle after release: grant req0->port0, req1->port1. Next cycle: outputs show req0/req1 prd/data, and rr_ptr=2.
- All 3 valid continuously for 3 cycles from rr_ptr=0 -> grant pairs (0,1), (2,0), (1,2). Every requester is granted twice, with no gap longer than 2 cycles.
- Only req1 valid, prd=7, data=0xDEAD -> req_ready[1]=1 each cycle. Next cycle writeback0_valid=1, prd=7, data=0xDEAD, writeback1_valid=0.
- flush_valid with flag=0, idx=10. req0 robidx (0,12), req1 (0,5), req2 (1,3) -> req0 and req2 squashed (ready=1, not forwarded). req1 goes to port0; port1 is idle next cycle.
- Wrap case: flush (1,2), req0 (0,60) -> older, not squashed, granted. Then req0 (1,2), equal to the flush -> not squashed.
- Reset asserted the cycle after a grant -> following cycle writeback*_valid=0 and rr_ptr=0.
